// File: rtl/fifo_wptr_ctrl_pkg.sv
// fifo_wptr_ctrl_pkg: shared pointer helpers for the async FIFO write and read controllers
package fifo_wptr_ctrl_pkg;

    // FIFO depth derived from the RAM address width
    function automatic int depth_of(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Binary to reflected Gray code
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of itself and all higher bits
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_gray_sync.sv
// gray_sync: two-flop synchronizer for a Gray-coded pointer crossing clock domains
module gray_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q1;

    // Two-stage shift; only one bit of d changes at a time so q is always a valid pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end
endmodule

// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl: write-side pointer, full/almost-full, fill level and overflow for the async FIFO
module fifo_wptr_ctrl
    import fifo_wptr_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE      = 4,
    parameter int ALMOST_FULL_TH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 ovf_clr,
    input  logic [ADDR_SIZE:0]   rd_gray_ptr,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_gray_ptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   fill_level,
    output logic                 wr_ovf
);
    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = depth_of(ADDR_SIZE);

    logic [PW-1:0] wbin, wbin_next, wgray, wgray_next, rq2, rbin;
    logic          full_next;

    gray_sync #(.WIDTH(PW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rd_gray_ptr),
        .q     (rq2)
    );

    assign mem_we      = wr_en & ~full;
    assign wbin_next   = wbin + PW'(mem_we);
    assign wgray_next  = PW'(bin2gray(32'(wbin_next)));
    assign rbin        = PW'(gray2bin(32'(rq2)));
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal
    assign full_next   = wgray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    assign fill_level  = wbin - rbin;
    assign almost_full = fill_level >= PW'(DEPTH - ALMOST_FULL_TH);
    assign wr_addr     = wbin[ADDR_SIZE-1:0];
    assign wr_gray_ptr = wgray;

    // Pointer, full and sticky overflow registers; a set of wr_ovf beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin   <= '0;
            wgray  <= '0;
            full   <= 1'b0;
            wr_ovf <= 1'b0;
        end else begin
            wbin   <= wbin_next;
            wgray  <= wgray_next;
            full   <= full_next;
            wr_ovf <= (wr_en & full) | (wr_ovf & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb_fifo_wptr_ctrl: directed and random checks of the write pointer controller against a counter model
module tb_fifo_wptr_ctrl;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       wr_en = 0;
    logic       ovf_clr = 0;
    logic [4:0] rd_gray_ptr;
    logic       mem_we;
    logic [3:0] wr_addr;
    logic [4:0] wr_gray_ptr;
    logic       full;
    logic       almost_full;
    logic [4:0] fill_level;
    logic       wr_ovf;

    int total = 0;
    int bad = 0;
    int rp = 0;
    int m_w = 0;
    int m_full = 0;
    int m_ovf = 0;
    int d1 = 0;
    int d2 = 0;
    int have_prev = 0;
    logic [4:0] prev_g = '0;

    assign rd_gray_ptr = 5'(rp ^ (rp >> 1));

    fifo_wptr_ctrl #(.ADDR_SIZE(4), .ALMOST_FULL_TH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .ovf_clr     (ovf_clr),
        .rd_gray_ptr (rd_gray_ptr),
        .mem_we      (mem_we),
        .wr_addr     (wr_addr),
        .wr_gray_ptr (wr_gray_ptr),
        .full        (full),
        .almost_full (almost_full),
        .fill_level  (fill_level),
        .wr_ovf      (wr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int m_fill();
        return (m_w - d2 + 32) % 32;
    endfunction

    function automatic int m_next_w();
        return (m_w + ((wr_en && m_full == 0) ? 1 : 0)) % 32;
    endfunction

    // Model: count of accepted writes mod 32, read pointer seen two edges late
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_w <= 0; m_full <= 0; m_ovf <= 0; d1 <= 0; d2 <= 0;
        end else begin
            m_ovf  <= (wr_en && m_full != 0) ? 1 : (ovf_clr ? 0 : m_ovf);
            m_full <= ((m_next_w() - d2 + 32) % 32 == 16) ? 1 : 0;
            m_w    <= m_next_w();
            d2     <= d1;
            d1     <= rp;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wr_addr", wr_addr, m_w % 16);
            chk("wr_gray_ptr", wr_gray_ptr, m_w ^ (m_w >> 1));
            chk("full", full, m_full);
            chk("fill_level", fill_level, m_fill());
            chk("almost_full", almost_full, m_fill() >= 14 ? 1 : 0);
            chk("wr_ovf", wr_ovf, m_ovf);
            chk("mem_we", mem_we, (wr_en && m_full == 0) ? 1 : 0);
            if (have_prev != 0 && wr_gray_ptr != prev_g)
                chk("gray_one_bit_step", $countones(wr_gray_ptr ^ prev_g), 1);
            prev_g = wr_gray_ptr;
            have_prev = 1;
        end else
            have_prev = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst_n = 1;
        chk("rst_full", full, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_gray", wr_gray_ptr, 0);
        chk("rst_ovf", wr_ovf, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1;
            #1;
            chk("fill_mem_we", mem_we, 1);
            chk("fill_addr", wr_addr, i);
            chk("fill_almost", almost_full, i >= 14 ? 1 : 0);
            tick();
        end
        wr_en = 0;
        chk("full_after16", full, 1);
        chk("gray_after16", wr_gray_ptr, 5'b11000);
        chk("fill_after16", fill_level, 16);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1;
            #1;
            chk("refused_mem_we", mem_we, 0);
            tick();
        end
        chk("refused_gray", wr_gray_ptr, 5'b11000);
        chk("ovf_set", wr_ovf, 1);
        ovf_clr = 1;
        tick();
        chk("ovf_set_wins", wr_ovf, 1);
        wr_en = 0;
        tick();
        chk("ovf_cleared", wr_ovf, 0);
        ovf_clr = 0;
        rp = 1;
        tick();
        chk("rd1_fill", fill_level, 16);
        chk("rd1_full", full, 1);
        tick();
        chk("rd2_fill", fill_level, 15);
        chk("rd2_full", full, 1);
        tick();
        chk("rd3_full", full, 0);
        wr_en = 1;
        #1;
        chk("after_free_we", mem_we, 1);
        chk("after_free_addr", wr_addr, 0);
        tick();
        n = 0;
        while (m_w != 0 && n < 300) begin
            wr_en = 1;
            if ((m_w - rp + 32) % 32 > 0) rp = (rp + 1) % 32;
            tick();
            n++;
        end
        chk("wrap_reached", n < 300 ? 1 : 0, 1);
        chk("wrap_gray", wr_gray_ptr, 0);
        chk("wrap_addr", wr_addr, 0);
        for (int i = 0; i < 400; i++) begin
            wr_en = $urandom_range(0, 9) < 7;
            ovf_clr = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 1) == 1 && (m_w - rp + 32) % 32 > 0) rp = (rp + 1) % 32;
            tick();
        end
        wr_en = 0;
        ovf_clr = 0;
        n = 0;
        while (rp != m_w && n < 100) begin
            rp = (rp + 1) % 32;
            tick();
            n++;
        end
        repeat (3) tick();
        n = 0;
        while (m_fill() < 9 && n < 100) begin
            wr_en = 1;
            tick();
            n++;
        end
        chk("pre_reset_fill", fill_level, 9);
        #2;
        rst_n = 0;
        rp = 0;
        #1;
        chk("async_addr", wr_addr, 0);
        chk("async_gray", wr_gray_ptr, 0);
        chk("async_full", full, 0);
        chk("async_fill", fill_level, 0);
        chk("async_almost", almost_full, 0);
        chk("async_ovf", wr_ovf, 0);
        chk("async_mem_we", mem_we, 1);
        @(negedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("resume_we", mem_we, 1);
        chk("resume_addr0", wr_addr, 0);
        tick();
        chk("resume_addr1", wr_addr, 1);
        wr_en = 0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
